// File: rtl/ps_interrupt_controller.sv
// Prioritised 4-source interrupt controller for the 8-bit-PC program sequencer.
// Latches requests, arbitrates by fixed priority (bit 0 highest), forces a
// vectored jump, saves the return address and restores it on rti.
module ps_interrupt_controller #(
    parameter logic [3:0] VEC_BASE  = 4'hC,
    parameter bit         EDGE_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic [3:0] irq,
    input  logic       hold,
    input  logic [7:0] pm_addr_in,
    input  logic       ie_set,
    input  logic       ie_clr,
    input  logic       mask_wr,
    input  logic [3:0] mask_data,
    input  logic       rti,
    output logic       int_jmp,
    output logic [3:0] int_vec,
    output logic       ret_jmp,
    output logic [7:0] ret_addr,
    output logic       in_isr,
    output logic [1:0] active_id,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {StIdle, StEnter, StIsr, StReturn} state_e;

    state_e     state_q;
    logic       ie_q;
    logic [3:0] mask_q;
    logic [3:0] pending_q;
    logic [3:0] irq_d_q;
    logic [7:0] ret_addr_q;
    logic [1:0] active_id_q;

    logic [3:0] req_set;
    logic [3:0] eligible;
    logic [3:0] ack;
    logic [1:0] winner;
    logic       enter_go;
    logic       return_go;

    // Request capture, eligibility and acknowledge of the source being entered.
    always_comb begin
        req_set   = EDGE_MODE ? (irq & ~irq_d_q) : irq;
        eligible  = pending_q & mask_q;
        enter_go  = (state_q == StEnter) && !hold;
        return_go = (state_q == StReturn) && !hold;
        ack       = enter_go ? (4'b0001 << active_id_q) : 4'b0000;
    end

    // Fixed priority: lowest set index wins.
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) winner = 2'(i);
        end
    end

    // Sequencer-steering state machine plus enable, mask and pending state.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q     <= StIdle;
            ie_q        <= 1'b0;
            mask_q      <= 4'h0;
            pending_q   <= 4'h0;
            irq_d_q     <= 4'h0;
            ret_addr_q  <= 8'h00;
            active_id_q <= 2'd0;
        end else begin
            irq_d_q   <= irq;
            // A fresh request on the acknowledge cycle survives (set wins).
            pending_q <= (pending_q & ~ack) | req_set;
            if (mask_wr) mask_q <= mask_data;
            if (ie_clr) begin
                ie_q <= 1'b0;
            end else if (ie_set) begin
                ie_q <= 1'b1;
            end
            // State-driven ie updates below override the instruction updates.
            unique case (state_q)
                StIdle: begin
                    if (ie_q && (eligible != 4'h0)) begin
                        state_q     <= StEnter;
                        active_id_q <= winner;
                    end
                end
                StEnter: begin
                    if (!hold) begin
                        ret_addr_q <= pm_addr_in;
                        ie_q       <= 1'b0;
                        state_q    <= StIsr;
                    end
                end
                StIsr: begin
                    if (rti) state_q <= StReturn;
                end
                StReturn: begin
                    if (!hold) begin
                        ie_q    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Redirect strobes are qualified by hold so no jump issues during a stall.
    always_comb begin
        int_jmp   = enter_go;
        ret_jmp   = return_go;
        int_vec   = (state_q == StEnter) ? (VEC_BASE + {2'b00, active_id_q}) : 4'h0;
        in_isr    = (state_q == StIsr) || (state_q == StReturn);
        ret_addr  = ret_addr_q;
        active_id = active_id_q;
        pending   = pending_q;
    end

    // The highest vector nibble must not wrap past 4'hF.
    always_ff @(posedge clk) begin
        assert ({1'b0, VEC_BASE} + 5'd3 <= 5'd15)
            else $error("VEC_BASE too large: vector table would wrap");
    end

endmodule

// File: tb/tb_ps_interrupt_controller.sv
// Scoreboard bench for ps_interrupt_controller: the stimulus process runs a
// behavioural model and queues expected redirects; a monitor pops and compares.
module tb_ps_interrupt_controller;

    localparam logic [3:0] VEC_BASE = 4'hC;

    logic       clk = 1'b0;
    logic       sync_reset, hold, ie_set, ie_clr, mask_wr, rti;
    logic [3:0] irq, mask_data;
    logic [7:0] pm_addr_in;
    logic       int_jmp, ret_jmp, in_isr;
    logic [3:0] int_vec, pending;
    logic [7:0] ret_addr;
    logic [1:0] active_id;

    always #5 clk = ~clk;

    ps_interrupt_controller #(
        .VEC_BASE  (VEC_BASE),
        .EDGE_MODE (1'b1)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .irq        (irq),
        .hold       (hold),
        .pm_addr_in (pm_addr_in),
        .ie_set     (ie_set),
        .ie_clr     (ie_clr),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .rti        (rti),
        .int_jmp    (int_jmp),
        .int_vec    (int_vec),
        .ret_jmp    (ret_jmp),
        .ret_addr   (ret_addr),
        .in_isr     (in_isr),
        .active_id  (active_id),
        .pending    (pending)
    );

    typedef struct {
        bit         is_ret;
        int         cyc;
        logic [7:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  started  = 1'b0;

    // Behavioural model: pending requests, enable, mask, and what the
    // controller still owes the sequencer (a vectored jump or a return).
    bit [3:0] m_pend, m_mask, m_prev;
    bit       m_ie, m_owed_jump, m_busy, m_owed_ret, m_fresh;
    int       m_src;
    bit [7:0] m_saved;
    bit       e_int, e_ret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic int lowest(input bit [3:0] v);
        for (int n = 0; n < 4; n++) if (v[n]) return n;
        return -1;
    endfunction

    task automatic model_update();
        bit [3:0] newreq;
        bit       old_ie;
        bit [3:0] old_mask;
        newreq   = irq & ~m_prev;
        old_ie   = m_ie;
        old_mask = m_mask;
        if (sync_reset) begin
            m_pend = 0; m_mask = 0; m_prev = 0; m_ie = 0;
            m_owed_jump = 0; m_busy = 0; m_owed_ret = 0;
            m_src = 0; m_saved = 0; m_fresh = 1;
            return;
        end
        m_fresh = 0;
        if (ie_clr) m_ie = 0;
        else if (ie_set) m_ie = 1;
        if (mask_wr) m_mask = mask_data;
        if (e_int) begin
            m_pend[m_src] = 0;
            m_saved       = pm_addr_in;
            m_ie          = 0;
            m_owed_jump   = 0;
            m_busy        = 1;
        end else if (e_ret) begin
            m_ie       = 1;
            m_owed_ret = 0;
            m_busy     = 0;
        end else if (!m_owed_jump && !m_busy && old_ie && ((m_pend & old_mask) != 0)) begin
            m_src       = lowest(m_pend & old_mask);
            m_owed_jump = 1;
        end else if (m_busy && !m_owed_ret && rti) begin
            m_owed_ret = 1;
        end
        m_pend = m_pend | newreq;
        m_prev = irq;
    endtask

    // Apply the current inputs for one cycle, queue predicted redirects.
    task automatic tick();
        ev_t ev;
        e_int = m_owed_jump && !hold;
        e_ret = m_owed_ret && !hold;
        if (e_int) begin
            ev.is_ret = 0; ev.cyc = cyc; ev.val = 8'(int'(VEC_BASE) + m_src);
            exp_q.push_back(ev);
        end
        if (e_ret) begin
            ev.is_ret = 1; ev.cyc = cyc; ev.val = m_saved;
            exp_q.push_back(ev);
        end
        started = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        cyc++;
    endtask

    task automatic clr_pulses();
        ie_set = 0; ie_clr = 0; mask_wr = 0; rti = 0;
    endtask

    // Monitor: compare redirects against the queue and state against the model.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (started) begin
                check("jmp_exclusive", 32'(int_jmp & ret_jmp), 32'(0));
                if (int_jmp || ret_jmp) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_jump at cycle %0d: got int_jmp=%0b ret_jmp=%0b, expected none",
                                 cyc, int_jmp, ret_jmp);
                    end else begin
                        ev = exp_q.pop_front();
                        check("jump_kind", 32'(ret_jmp), 32'(ev.is_ret));
                        check("jump_cycle", 32'(cyc), 32'(ev.cyc));
                        if (ev.is_ret) check("ret_jmp_addr", 32'(ret_addr), 32'(ev.val));
                        else           check("int_vec", 32'(int_vec), 32'(ev.val));
                    end
                end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    ev = exp_q.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missed_jump at cycle %0d: got none, expected %s",
                             cyc, ev.is_ret ? "ret_jmp" : "int_jmp");
                end
                check("pending", 32'(pending), 32'(m_pend));
                check("in_isr", 32'(in_isr), 32'(m_busy));
                check("ret_addr", 32'(ret_addr), 32'(m_saved));
                check("active_id", 32'(active_id), 32'(m_src));
                if (m_fresh) begin
                    check("reset_int_vec", 32'(int_vec), 32'(0));
                    check("reset_int_jmp", 32'(int_jmp), 32'(0));
                    check("reset_ret_jmp", 32'(ret_jmp), 32'(0));
                end
            end
        end
    end

    initial begin
        m_pend = 0; m_mask = 0; m_prev = 0; m_ie = 0; m_owed_jump = 0;
        m_busy = 0; m_owed_ret = 0; m_fresh = 0; m_src = 0; m_saved = 0;
        sync_reset = 1; hold = 0; irq = 0; pm_addr_in = 0; mask_data = 0;
        clr_pulses();
        tick(); tick();
        sync_reset = 0;
        tick();

        // Single edge request, vector 4'hE, return address 8'h13.
        ie_set = 1; mask_wr = 1; mask_data = 4'hF; tick(); clr_pulses();
        pm_addr_in = 8'h13; irq = 4'b0100; tick(); irq = 0;
        repeat (3) tick();
        rti = 1; tick(); rti = 0;
        repeat (2) tick();

        // Simultaneous sources 1 and 3: 1 first, then 3 back-to-back.
        pm_addr_in = 8'h27; irq = 4'b1010; tick(); irq = 0;
        repeat (4) tick();
        pm_addr_in = 8'h31; rti = 1; tick(); rti = 0;
        repeat (4) tick();
        rti = 1; tick(); rti = 0;
        repeat (3) tick();

        // Request arriving while the sequencer stalls.
        hold = 1; irq = 4'b0001; pm_addr_in = 8'h40; tick(); irq = 0;
        tick(); tick();
        hold = 0; pm_addr_in = 8'h5A; tick();
        repeat (2) tick();
        rti = 1; tick(); rti = 0;
        repeat (2) tick();

        // Masked source stays pending until unmasked.
        mask_wr = 1; mask_data = 4'h0; tick(); clr_pulses();
        irq = 4'b0001; tick(); irq = 0;
        repeat (3) tick();
        mask_wr = 1; mask_data = 4'h1; tick(); clr_pulses();
        repeat (3) tick();
        rti = 1; tick(); rti = 0;
        repeat (2) tick();

        // Edge during ISR waits for return; set+clr leaves ie off; stray rti.
        mask_wr = 1; mask_data = 4'hF; irq = 4'b0100; tick(); clr_pulses(); irq = 0;
        repeat (3) tick();
        irq = 4'b0001; tick(); irq = 0;
        repeat (2) tick();
        rti = 1; tick(); rti = 0;
        repeat (4) tick();
        rti = 1; tick(); rti = 0;
        repeat (2) tick();
        ie_set = 1; ie_clr = 1; tick(); clr_pulses();
        irq = 4'b0010; tick(); irq = 0;
        repeat (3) tick();
        rti = 1; tick(); rti = 0;
        tick();
        ie_set = 1; tick(); clr_pulses();
        repeat (3) tick();
        rti = 1; tick(); rti = 0;
        repeat (2) tick();

        // Reset in the middle of a held ENTER drops the redirect.
        hold = 1; irq = 4'b1000; tick(); irq = 0;
        tick(); tick();
        sync_reset = 1; tick(); sync_reset = 0; hold = 0;
        repeat (5) tick();

        // Randomised traffic.
        ie_set = 1; mask_wr = 1; mask_data = 4'hF; tick(); clr_pulses();
        repeat (3000) begin
            irq        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            hold       = ($urandom_range(0, 3) == 0);
            ie_set     = ($urandom_range(0, 15) == 0);
            ie_clr     = ($urandom_range(0, 31) == 0);
            mask_wr    = ($urandom_range(0, 31) == 0);
            mask_data  = 4'($urandom);
            rti        = ($urandom_range(0, 7) == 0);
            pm_addr_in = 8'($urandom);
            sync_reset = ($urandom_range(0, 499) == 0);
            tick();
        end

        sync_reset = 0; hold = 0; irq = 0; clr_pulses();
        repeat (4) tick();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps_interrupt_controller.md
Name: ps_interrupt_controller

Overview:
- Prioritised 4-source interrupt controller that steers the program sequencer.
- Latches interrupt requests and arbitrates them by fixed priority.
- Forces a vectored jump through the sequencer's 4-bit jump-address path and saves the return address.
- Restores that address on return-from-interrupt. Sits beside the program sequencer and instruction decoder in the 8-bit-PC microcontroller.

Parameters:
VEC_BASE, 4'hC, upper-nibble base of the vector table; source n vectors to pm address {VEC_BASE+n, 4'h0}; VEC_BASE+3 must not exceed 4'hF.
EDGE_MODE, 1, 1 = rising-edge-triggered requests, 0 = level-triggered.

Ports:
clk  in  1  system clock; all state updates on the rising edge
sync_reset  in  1  synchronous, active-high reset
irq  in  4  interrupt requests; bit 0 is highest priority
hold  in  1  sequencer is stalling (NOPD8 delay active); no redirect may issue while high
pm_addr_in  in  8  sequencer's next fetch address this cycle, without interrupt influence
ie_set  in  1  decoded "enable interrupts" instruction
ie_clr  in  1  decoded "disable interrupts" instruction
mask_wr  in  1  load mask register
mask_data  in  4  new mask (1 = source enabled)
rti  in  1  decoded return-from-interrupt instruction
int_jmp  out  1  force the sequencer to jump to {int_vec,4'h0}
int_vec  out  4  vector nibble
ret_jmp  out  1  force the sequencer to jump to ret_addr
ret_addr  out  8  saved return address
in_isr  out  1  an ISR is executing
active_id  out  2  source currently being serviced
pending  out  4  latched, not-yet-acknowledged requests

Behaviour:
- Reset values: state IDLE; ie=0; mask=4'h0; pending=0; irq_d (edge-detect register)=0; ret_addr=8'h00; active_id=0. All outputs are 0.
- Request capture:
  - EDGE_MODE=1: pending[n] sets on irq[n] & ~irq_d[n].
  - EDGE_MODE=0: pending[n] sets while irq[n]=1.
  - Pending bits are kept regardless of mask or ie.
  - pending[n] clears only on the cycle source n is acknowledged (ENTER issues). A new edge on the same cycle re-sets the bit (set wins).
- Enable and mask:
  - ie: ie_set sets, ie_clr clears; if both are asserted, clear wins.
  - mask loads on mask_wr.
  - ie and mask changes take effect for eligibility on the following cycle.
- Eligibility: eligible = pending & mask. The winner is the lowest-index set bit.
- State machine (registered):
  - IDLE: if ie=1 and eligible!=0, go to ENTER and latch active_id=winner.
  - ENTER:
    - int_jmp = ~hold.
    - int_vec = VEC_BASE + active_id, stable throughout ENTER.
    - While hold=1, remain in ENTER with int_jmp=0.
    - On the first cycle with hold=0: capture ret_addr <= pm_addr_in, clear pending[active_id], clear ie, go to ISR.
    - Hence int_jmp is high for exactly one cycle and the sequencer fetches vector address {int_vec,4'h0} next.
  - ISR:
    - in_isr=1. Nesting is not supported: new requests only accumulate in pending.
    - rti=1 goes to RETURN.
  - RETURN:
    - ret_jmp = ~hold; in_isr stays 1. While hold=1, remain with ret_jmp=0.
    - On the first cycle with hold=0: set ie=1 and go to IDLE.
    - A pending eligible request is taken next, giving a back-to-back ENTER two cycles after ret_jmp.
- Mutual exclusion: int_jmp and ret_jmp are never asserted together. Neither output is asserted in IDLE or ISR.
- rti outside ISR is ignored. ie_set/ie_clr inside ISR update ie, but ie is forced to 1 on RETURN exit.
- sync_reset in any state returns to the reset values on the next edge, including mid-ENTER or mid-RETURN. The pending redirect is dropped.
- Arithmetic: int_vec = VEC_BASE + {2'b00, active_id}, 4 bits. No wrap is permitted; this is a parameter constraint checked by an assertion.

Test Plan:
1. Reset, ie_set, mask_wr 4'hF, irq[2] pulse with pm_addr_in=8'h13: ENTER one cycle later; int_jmp=1 for one cycle; int_vec=4'hE; ret_addr=8'h13; pending[2] cleared; ie=0.
2. irq[1] and irq[3] rise in the same cycle: source 1 serviced first (int_vec=4'hD). On rti, ret_jmp fires with the saved address; two cycles later int_jmp with int_vec=4'hF.
3. Request arrives while hold=1 for 2 cycles: int_jmp stays 0 until hold drops, then pulses once. ret_addr equals pm_addr_in from the hold=0 cycle.
4. mask=4'h0 and irq[0] edge: pending=4'h1 and no int_jmp. mask_wr 4'h1: ENTER follows and int_vec=4'hC.
5. irq[0] edge during ISR: no int_jmp until after ret_jmp. Same-cycle ie_set+ie_clr leaves ie=0. rti in IDLE produces no ret_jmp.
6. sync_reset asserted during ENTER with hold=1: next cycle all outputs are 0, pending=0, and no jump is issued afterwards.
